// File: rtl/axi_lite_frontend.sv
// AXI4-Lite slave front end: terminates AW/W/B/AR/R and turns each accepted
// transaction into a single-cycle word-indexed access on the prewrapper port.
module axi_lite_frontend #(
    parameter int unsigned p_sc_nbr    = 16,
    parameter logic [31:0] p_null_addr = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,

    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,

    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,

    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,

    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,

    output logic [31:0] axi_rd_addr,
    input  logic [31:0] axi_rd_msg,
    output logic [31:0] axi_wr_addr,
    output logic [31:0] axi_wr_msg
);

    localparam logic [31:0] reg_cnt = 32'(p_sc_nbr + 5);
    localparam logic [1:0]  resp_okay   = 2'b00;
    localparam logic [1:0]  resp_slverr = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        aw_full;
    logic        w_full;
    logic        ar_full;
    logic        prio;
    logic        aw_full_nxt;
    logic        w_full_nxt;
    logic        ar_full_nxt;
    logic        prio_nxt;
    logic        wr_pend;
    logic        rd_pend;

    logic [31:0] awaddr_hold;
    logic [31:0] wdata_hold;
    logic [3:0]  wstrb_hold;
    logic [31:0] araddr_hold;

    logic        wr_ok;
    logic        rd_ok;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;

    logic [31:0] aw_cur;
    logic [31:0] w_cur;
    logic [3:0]  strb_cur;
    logic [31:0] ar_cur;
    logic [31:0] aw_idx;
    logic [31:0] ar_idx;
    logic        wr_legal;
    logic        rd_legal;

    function automatic logic [31:0] word_idx(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid  & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // A transaction can leave IDLE in the same cycle its last beat handshakes,
    // so decode from the live channel when the holding register is still empty.
    assign aw_cur   = aw_full ? awaddr_hold : s_axi_awaddr;
    assign w_cur    = w_full  ? wdata_hold  : s_axi_wdata;
    assign strb_cur = w_full  ? wstrb_hold  : s_axi_wstrb;
    assign ar_cur   = ar_full ? araddr_hold : s_axi_araddr;

    assign aw_idx   = word_idx(aw_cur);
    assign ar_idx   = word_idx(ar_cur);
    assign wr_legal = (aw_idx < reg_cnt) && (strb_cur == 4'hF);
    assign rd_legal = (ar_idx < reg_cnt);

    always_comb begin
        state_nxt   = state;
        prio_nxt    = prio;
        aw_full_nxt = aw_full | aw_hs;
        w_full_nxt  = w_full  | w_hs;
        ar_full_nxt = ar_full | ar_hs;
        wr_pend     = aw_full_nxt & w_full_nxt;
        rd_pend     = ar_full_nxt;
        case (state)
            IDLE: begin
                // prio flips each time it resolves a contest between a
                // complete write and a pending read
                if (wr_pend && rd_pend) begin
                    state_nxt = prio ? RD_ISSUE : WR_ISSUE;
                    prio_nxt  = ~prio;
                end else if (wr_pend) begin
                    state_nxt = WR_ISSUE;
                end else if (rd_pend) begin
                    state_nxt = RD_ISSUE;
                end
            end
            WR_ISSUE: state_nxt = WR_RESP;
            WR_RESP: begin
                if (s_axi_bready) begin
                    state_nxt   = IDLE;
                    aw_full_nxt = 1'b0;
                    w_full_nxt  = 1'b0;
                end
            end
            RD_ISSUE: state_nxt = RD_RESP;
            RD_RESP: begin
                if (s_axi_rready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state == IDLE && state_nxt == RD_ISSUE) begin
            ar_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            ar_full       <= 1'b0;
            prio          <= 1'b0;
            wr_ok         <= 1'b0;
            rd_ok         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= resp_okay;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= resp_okay;
            s_axi_rdata   <= 32'h0;
            axi_rd_addr   <= p_null_addr;
            axi_wr_addr   <= p_null_addr;
            axi_wr_msg    <= 32'h0;
        end else begin
            state         <= state_nxt;
            aw_full       <= aw_full_nxt;
            w_full        <= w_full_nxt;
            ar_full       <= ar_full_nxt;
            prio          <= prio_nxt;
            s_axi_awready <= (state_nxt == IDLE) && !aw_full_nxt;
            s_axi_wready  <= (state_nxt == IDLE) && !w_full_nxt;
            s_axi_arready <= (state_nxt == IDLE) && !aw_full_nxt && !w_full_nxt && !ar_full_nxt;
            case (state)
                IDLE: begin
                    if (state_nxt == WR_ISSUE) begin
                        wr_ok <= wr_legal;
                        if (wr_legal) begin
                            axi_wr_addr <= aw_idx;
                            axi_wr_msg  <= w_cur;
                        end
                    end
                    if (state_nxt == RD_ISSUE) begin
                        rd_ok <= rd_legal;
                        if (rd_legal) begin
                            axi_rd_addr <= ar_idx;
                        end
                    end
                end
                WR_ISSUE: begin
                    axi_wr_addr  <= p_null_addr;
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= wr_ok ? resp_okay : resp_slverr;
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                    end
                end
                RD_ISSUE: begin
                    axi_rd_addr  <= p_null_addr;
                    s_axi_rvalid <= 1'b1;
                    s_axi_rdata  <= rd_ok ? axi_rd_msg : 32'h0;
                    s_axi_rresp  <= rd_ok ? resp_okay : resp_slverr;
                end
                RD_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Holding registers carry data only; aw_full/w_full/ar_full qualify them.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            awaddr_hold <= s_axi_awaddr;
        end
        if (w_hs) begin
            wdata_hold <= s_axi_wdata;
            wstrb_hold <= s_axi_wstrb;
        end
        if (ar_hs) begin
            araddr_hold <= s_axi_araddr;
        end
    end

endmodule
